// File: rtl/ct_idu_dep_preg_entry_param.sv
// Dependency-tracking entry for one physical register: follows the producer's
// wakeup (fixed-latency, speculative load, writeback) and reports readiness to issue.
module ct_idu_dep_preg_entry_param #(
  parameter int TAG_W    = 7,
  parameter int N_WAKE   = 6,
  parameter int N_WB     = 3,
  parameter int LAT_W    = 2,
  parameter int SPEC_WIN = 2
) (
  input  logic                      forever_cpuclk,
  input  logic                      cpurst,
  input  logic                      rtu_idu_flush_fe,
  input  logic                      rtu_idu_flush_is,
  input  logic                      x_write_en,
  input  logic [TAG_W-1:0]          x_create_tag,
  input  logic                      x_create_rdy,
  input  logic                      x_create_wb,
  input  logic                      x_rdy_clr,
  input  logic [N_WAKE-1:0]         wake_vld,
  input  logic [N_WAKE*TAG_W-1:0]   wake_tag,
  input  logic [N_WAKE*LAT_W-1:0]   wake_lat,
  input  logic                      ld_spec_vld,
  input  logic [TAG_W-1:0]          ld_spec_tag,
  input  logic                      ld_cancel_vld,
  input  logic [TAG_W-1:0]          ld_cancel_tag,
  input  logic [N_WB-1:0]           wb_vld,
  input  logic [N_WB*TAG_W-1:0]     wb_tag,
  output logic                      x_read_rdy,
  output logic                      x_read_rdy_for_issue,
  output logic                      x_read_spec,
  output logic                      x_read_wb,
  output logic [TAG_W-1:0]          x_read_tag
);

  typedef enum logic [2:0] {ST_WAIT, ST_CNT, ST_SPEC, ST_RDY, ST_DONE} state_t;

  localparam logic [1:0] SPEC_LAST = 2'(SPEC_WIN - 1);

  state_t             state_q, state_d;
  logic [LAT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         spec_age_q, spec_age_d;
  logic [TAG_W-1:0]   tag_q, tag_d;

  logic [N_WAKE-1:0]  wake_hit_vec;
  logic [N_WB-1:0]    wb_hit_vec;
  logic               wake_hit, wb_hit, spec_hit, cancel_hit;
  logic [LAT_W-1:0]   lat_min;
  state_t             wake_state;
  logic [LAT_W-1:0]   wake_cnt;

  genvar gi;
  generate
    for (gi = 0; gi < N_WAKE; gi++) begin : g_wake
      assign wake_hit_vec[gi] = wake_vld[gi] && (wake_tag[gi*TAG_W +: TAG_W] == tag_q);
    end
    for (gi = 0; gi < N_WB; gi++) begin : g_wb
      assign wb_hit_vec[gi] = wb_vld[gi] && (wb_tag[gi*TAG_W +: TAG_W] == tag_q);
    end
  endgenerate

  assign wake_hit   = |wake_hit_vec;
  assign wb_hit     = |wb_hit_vec;
  assign spec_hit   = ld_spec_vld && (ld_spec_tag == tag_q);
  assign cancel_hit = ld_cancel_vld && (ld_cancel_tag == tag_q);

  // Shortest latency among matching wake ports wins.
  always_comb begin
    lat_min = '1;
    for (int i = 0; i < N_WAKE; i++) begin
      if (wake_hit_vec[i] && (wake_lat[i*LAT_W +: LAT_W] < lat_min)) begin
        lat_min = wake_lat[i*LAT_W +: LAT_W];
      end
    end
  end

  assign wake_state = (lat_min == '0) ? ST_RDY : ST_CNT;
  assign wake_cnt   = (lat_min == '0) ? '0 : lat_min - LAT_W'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    spec_age_d = spec_age_q;
    tag_d      = tag_q;
    if (rtu_idu_flush_fe || rtu_idu_flush_is) begin
      state_d    = ST_DONE;
      cnt_d      = '0;
      spec_age_d = '0;
    end else if (x_write_en) begin
      tag_d      = x_create_tag;
      cnt_d      = '0;
      spec_age_d = '0;
      if (x_create_wb)       state_d = ST_DONE;
      else if (x_create_rdy) state_d = ST_RDY;
      else                   state_d = ST_WAIT;
    end else if (wb_hit) begin
      state_d    = ST_DONE;
      cnt_d      = '0;
      spec_age_d = '0;
    end else if (cancel_hit && state_q == ST_SPEC) begin
      // The load missed; a fixed-latency wake in the same cycle restarts from WAIT.
      spec_age_d = '0;
      state_d    = ST_WAIT;
      if (wake_hit) begin
        state_d = wake_state;
        cnt_d   = wake_cnt;
      end
    end else if (x_rdy_clr && (state_q == ST_CNT || state_q == ST_SPEC || state_q == ST_RDY)) begin
      state_d    = ST_WAIT;
      cnt_d      = '0;
      spec_age_d = '0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (wake_hit) begin
            state_d = wake_state;
            cnt_d   = wake_cnt;
          end else if (spec_hit) begin
            state_d    = ST_SPEC;
            spec_age_d = '0;
          end
        end
        ST_CNT: begin
          if (wake_hit && (lat_min == '0)) begin
            state_d = ST_RDY;
            cnt_d   = '0;
          end else if (wake_hit && (wake_cnt < cnt_q)) begin
            cnt_d = wake_cnt;
          end else if (cnt_q == '0) begin
            state_d = ST_RDY;
          end else begin
            cnt_d = cnt_q - LAT_W'(1);
          end
        end
        ST_SPEC: begin
          if (wake_hit) begin
            state_d    = wake_state;
            cnt_d      = wake_cnt;
            spec_age_d = '0;
          end else if (spec_age_q == SPEC_LAST) begin
            state_d    = ST_RDY;
            spec_age_d = '0;
          end else begin
            spec_age_d = spec_age_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      state_q    <= ST_DONE;
      cnt_q      <= '0;
      spec_age_q <= '0;
      tag_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      spec_age_q <= spec_age_d;
      tag_q      <= tag_d;
    end
  end

  assign x_read_rdy           = (state_d == ST_SPEC) || (state_d == ST_RDY) || (state_d == ST_DONE);
  assign x_read_rdy_for_issue = (state_q == ST_RDY) || (state_q == ST_DONE) ||
                                ((state_q == ST_SPEC) && !cancel_hit);
  assign x_read_spec          = (state_q == ST_SPEC);
  assign x_read_wb            = (state_q == ST_DONE) || wb_hit;
  assign x_read_tag           = tag_q;

endmodule

// File: tb/tb_ct_idu_dep_preg_entry_param.sv
// Directed bench for the dependency entry: create, wake, speculative load,
// writeback, flush, ready-clear and reset scenarios.
module tb_ct_idu_dep_preg_entry_param;

  localparam int TAG_W = 7, N_WAKE = 6, N_WB = 3, LAT_W = 2;

  logic clk, rst;
  logic flush_fe, flush_is, write_en, create_rdy, create_wb, rdy_clr;
  logic [TAG_W-1:0] create_tag, spec_tag, cancel_tag;
  logic spec_vld, cancel_vld;
  logic [N_WAKE-1:0] wake_vld;
  logic [N_WAKE*TAG_W-1:0] wake_tag;
  logic [N_WAKE*LAT_W-1:0] wake_lat;
  logic [N_WB-1:0] wb_vld;
  logic [N_WB*TAG_W-1:0] wb_tag;
  logic rd_rdy, rd_issue, rd_spec, rd_wb;
  logic [TAG_W-1:0] rd_tag;

  int total = 0;
  int bad = 0;

  ct_idu_dep_preg_entry_param dut (
    .forever_cpuclk(clk), .cpurst(rst),
    .rtu_idu_flush_fe(flush_fe), .rtu_idu_flush_is(flush_is),
    .x_write_en(write_en), .x_create_tag(create_tag), .x_create_rdy(create_rdy),
    .x_create_wb(create_wb), .x_rdy_clr(rdy_clr),
    .wake_vld(wake_vld), .wake_tag(wake_tag), .wake_lat(wake_lat),
    .ld_spec_vld(spec_vld), .ld_spec_tag(spec_tag),
    .ld_cancel_vld(cancel_vld), .ld_cancel_tag(cancel_tag),
    .wb_vld(wb_vld), .wb_tag(wb_tag),
    .x_read_rdy(rd_rdy), .x_read_rdy_for_issue(rd_issue), .x_read_spec(rd_spec),
    .x_read_wb(rd_wb), .x_read_tag(rd_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    flush_fe = 0; flush_is = 0; write_en = 0; create_rdy = 0; create_wb = 0;
    rdy_clr = 0; create_tag = '0; spec_vld = 0; spec_tag = '0;
    cancel_vld = 0; cancel_tag = '0; wake_vld = '0; wake_tag = '0; wake_lat = '0;
    wb_vld = '0; wb_tag = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  task automatic create(input logic [TAG_W-1:0] t, input logic r, input logic w);
    write_en = 1; create_tag = t; create_rdy = r; create_wb = w;
    step();
  endtask

  task automatic set_wake(input int p, input logic [TAG_W-1:0] t, input logic [LAT_W-1:0] l);
    wake_vld[p] = 1'b1;
    wake_tag[p*TAG_W +: TAG_W] = t;
    wake_lat[p*LAT_W +: LAT_W] = l;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic test_reset();
    rst = 1; idle();
    #3;
    chk("reset_issue", 32'(rd_issue), 1);
    chk("reset_wb", 32'(rd_wb), 1);
    chk("reset_spec", 32'(rd_spec), 0);
    chk("reset_tag", 32'(rd_tag), 0);
    @(negedge clk); rst = 0;
    step();
  endtask

  task automatic test_wake_lat2();
    create(7'd5, 0, 0);
    chk("w2_wait_issue", 32'(rd_issue), 0);
    set_wake(2, 7'd5, 2'd2); #1;
    step();
    chk("w2_c1_issue", 32'(rd_issue), 0);
    step();
    chk("w2_c2_issue", 32'(rd_issue), 0);
    chk("w2_c2_rdy_next", 32'(rd_rdy), 1);
    step();
    chk("w2_c3_issue", 32'(rd_issue), 1);
  endtask

  task automatic test_spec_cancel();
    create(7'd9, 0, 0);
    spec_vld = 1; spec_tag = 7'd9; #1;
    chk("spec_rdy_comb", 32'(rd_rdy), 1);
    step();
    chk("spec_flag", 32'(rd_spec), 1);
    chk("spec_issue", 32'(rd_issue), 1);
    cancel_vld = 1; cancel_tag = 7'd9; #1;
    chk("cancel_issue", 32'(rd_issue), 0);
    chk("cancel_rdy_comb", 32'(rd_rdy), 0);
    step();
    chk("cancel_spec_off", 32'(rd_spec), 0);
    chk("cancel_wait_issue", 32'(rd_issue), 0);
    spec_vld = 1; spec_tag = 7'd9; #1;
    step();
    chk("spec2_age0", 32'(rd_spec), 1);
    step();
    chk("spec2_age1", 32'(rd_spec), 1);
    step();
    chk("spec2_rdy_spec", 32'(rd_spec), 0);
    chk("spec2_rdy_issue", 32'(rd_issue), 1);
  endtask

  task automatic test_wb();
    create(7'd3, 0, 0);
    set_wake(0, 7'd3, 2'd3); #1;
    step();
    chk("wb_cnt_wb", 32'(rd_wb), 0);
    chk("wb_cnt_issue", 32'(rd_issue), 0);
    wb_vld[1] = 1; wb_tag[1*TAG_W +: TAG_W] = 7'd3; #1;
    chk("wb_same_cycle", 32'(rd_wb), 1);
    step();
    chk("wb_done_wb", 32'(rd_wb), 1);
    chk("wb_done_issue", 32'(rd_issue), 1);
  endtask

  task automatic test_min_lat();
    create(7'd4, 0, 0);
    set_wake(0, 7'd4, 2'd3);
    set_wake(5, 7'd4, 2'd1); #1;
    step();
    chk("min_c1_issue", 32'(rd_issue), 0);
    step();
    chk("min_c2_issue", 32'(rd_issue), 1);
  endtask

  task automatic test_wake_zero();
    create(7'd2, 0, 0);
    set_wake(3, 7'd1, 2'd0); #1;
    chk("nomatch_rdy", 32'(rd_rdy), 0);
    step();
    chk("nomatch_issue", 32'(rd_issue), 0);
    set_wake(3, 7'd2, 2'd0); #1;
    chk("lat0_rdy_comb", 32'(rd_rdy), 1);
    step();
    chk("lat0_issue", 32'(rd_issue), 1);
  endtask

  task automatic test_flush_clr();
    create(7'd4, 0, 0);
    write_en = 1; create_tag = 7'd7; flush_is = 1; #1;
    step();
    chk("flush_done_wb", 32'(rd_wb), 1);
    chk("flush_tag_held", 32'(rd_tag), 4);
    create(7'd8, 1, 0);
    chk("rdy_tag", 32'(rd_tag), 8);
    chk("rdy_issue", 32'(rd_issue), 1);
    chk("rdy_wb", 32'(rd_wb), 0);
    rdy_clr = 1; #1;
    step();
    chk("clr_rdy_issue", 32'(rd_issue), 0);
    create(7'd8, 0, 1);
    rdy_clr = 1; #1;
    step();
    chk("clr_done_wb", 32'(rd_wb), 1);
    chk("clr_done_issue", 32'(rd_issue), 1);
  endtask

  task automatic test_reset_mid_cnt();
    create(7'd6, 0, 0);
    set_wake(1, 7'd6, 2'd3); #1;
    step();
    chk("rcnt_pre_issue", 32'(rd_issue), 0);
    rst = 1; #1;
    chk("rcnt_issue", 32'(rd_issue), 1);
    chk("rcnt_wb", 32'(rd_wb), 1);
    chk("rcnt_spec", 32'(rd_spec), 0);
    chk("rcnt_tag", 32'(rd_tag), 0);
    rst = 0;
    step(); step(); step();
    chk("rcnt_after_wb", 32'(rd_wb), 1);
    chk("rcnt_after_issue", 32'(rd_issue), 1);
  endtask

  initial begin
    test_reset();
    test_wake_lat2();
    test_spec_cancel();
    test_wb();
    test_min_lat();
    test_wake_zero();
    test_flush_clr();
    test_reset_mid_cnt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
